acorn_state_update: RTL and testbench

ACORN_STATE_UPDATE -- requirements
Module: acorn_state_update

---
 rtl/acorn_pkg.sv | 43 ++++
 rtl/acorn_state_update_if.sv | 32 +++
 rtl/acorn_step_func.sv | 39 +++
 rtl/acorn_state_update.sv | 90 +++++++++
 tb/tb_acorn_state_update.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/acorn_pkg.sv
// Shared constants for the ACORN state-update datapath: state width,
// default tag length, tag counter width and every state tap index.
// Also holds the two bitwise boolean helpers used by the step function.
package acorn_pkg;

    localparam int ACORN_STATE_BITS = 293;
    localparam int TAG_BITS_DEFAULT = 128;
    localparam int COUNT_BITS       = 8;

    // Six chained linear feedbacks, applied in this order:
    // S[LIN_DST[k]] ^= S[LIN_A[k]] ^ S[LIN_B[k]].
    localparam int LIN_STAGES = 6;
    localparam int LIN_DST [LIN_STAGES] = '{289, 230, 193, 154, 107, 61};
    localparam int LIN_A   [LIN_STAGES] = '{235, 196, 160, 111,  66, 23};
    localparam int LIN_B   [LIN_STAGES] = '{230, 193, 154, 107,  61,  0};

    // Keystream taps (read after the linear feedbacks).
    localparam int KS_T0    = 12;
    localparam int KS_T1    = 154;
    localparam int KS_MAJ_X = 235;
    localparam int KS_MAJ_Y = 61;
    localparam int KS_MAJ_Z = 193;
    localparam int KS_CH_X  = 230;
    localparam int KS_CH_Y  = 111;
    localparam int KS_CH_Z  = 66;

    // Nonlinear feedback taps.
    localparam int F_T0    = 0;
    localparam int F_T1    = 107;
    localparam int F_MAJ_X = 244;
    localparam int F_MAJ_Y = 23;
    localparam int F_MAJ_Z = 160;
    localparam int F_CA    = 196;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn_state_update_if.sv
// Control/data bundle between the encryption controller (master) and the
// ACORN state-update block (slave).
interface acorn_state_update_if
    import acorn_pkg::*;
#(
    parameter int TAG_BITS = TAG_BITS_DEFAULT
) ();

    logic                clr;
    logic                step_en;
    logic                mbit_in;
    logic                ca_in;
    logic                cb_in;
    logic                ct_en;
    logic                tag_en;
    logic                dec_mode;
    logic                ct_bit;
    logic                ct_valid;
    logic [TAG_BITS-1:0] tag_out;
    logic                tag_valid;

    modport master (
        output clr, step_en, mbit_in, ca_in, cb_in, ct_en, tag_en, dec_mode,
        input  ct_bit, ct_valid, tag_out, tag_valid
    );

    modport slave (
        input  clr, step_en, mbit_in, ca_in, cb_in, ct_en, tag_en, dec_mode,
        output ct_bit, ct_valid, tag_out, tag_valid
    );

endinterface

// File: rtl/acorn_step_func.sv
// Purely combinational ACORN step: linear feedbacks, keystream bit,
// nonlinear feedback and the one-position shift toward S[0].
module acorn_step_func
    import acorn_pkg::*;
(
    input  logic [ACORN_STATE_BITS-1:0] i_state,
    input  logic                        i_mbit,
    input  logic                        i_ca,
    input  logic                        i_cb,
    input  logic                        i_dec,
    output logic                        o_ks,
    output logic [ACORN_STATE_BITS-1:0] o_next
);

    logic [ACORN_STATE_BITS-1:0] w_lin;
    logic                        w_m;
    logic                        w_f;

    // Chained linear update, then keystream and feedback from updated bits.
    always_comb begin
        // NOTE: blocking assignments here are deliberate -- each feedback
        // must see the result of the previous one, and every output gets a
        // value on every pass so no latch is inferred.
        w_lin = i_state;
        for (int k = 0; k < LIN_STAGES; k++) begin
            w_lin[LIN_DST[k]] = w_lin[LIN_DST[k]] ^ w_lin[LIN_A[k]] ^ w_lin[LIN_B[k]];
        end
        o_ks = w_lin[KS_T0] ^ w_lin[KS_T1]
             ^ maj(w_lin[KS_MAJ_X], w_lin[KS_MAJ_Y], w_lin[KS_MAJ_Z])
             ^ ch(w_lin[KS_CH_X], w_lin[KS_CH_Y], w_lin[KS_CH_Z]);
        // In decrypt the incoming bit is ciphertext; the state absorbs plaintext.
        w_m = i_dec ? (i_mbit ^ o_ks) : i_mbit;
        w_f = w_lin[F_T0] ^ ~w_lin[F_T1]
            ^ maj(w_lin[F_MAJ_X], w_lin[F_MAJ_Y], w_lin[F_MAJ_Z])
            ^ (i_ca & w_lin[F_CA]) ^ (i_cb & o_ks) ^ w_m;
        o_next = {w_f, w_lin[ACORN_STATE_BITS-1:1]};
    end

endmodule

// File: rtl/acorn_state_update.sv
// ACORN state register, ciphertext output and tag collector.
// Optional feature: define ACORN_STATE_DECRYPT_EN to honour dec_mode
// (absorb recovered plaintext during decryption); otherwise dec_mode is ignored.
module acorn_state_update
    import acorn_pkg::*;
#(
    parameter int TAG_BITS = TAG_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acorn_state_update_if.slave  bus
);

    localparam logic [COUNT_BITS-1:0] TAG_LAST  = COUNT_BITS'(TAG_BITS - 1);
    localparam logic [COUNT_BITS:0]   TAG_LIMIT = (COUNT_BITS + 1)'(TAG_BITS);

    logic [ACORN_STATE_BITS-1:0] r_state;
    logic [TAG_BITS-1:0]         r_tag;
    logic [COUNT_BITS-1:0]       r_count;
    logic                        r_ct_bit;
    logic                        r_ct_valid;
    logic                        r_tag_valid;

    logic [ACORN_STATE_BITS-1:0] w_next;
    logic                        w_ks;
    logic                        w_dec;
    logic                        w_tag_room;

`ifdef ACORN_STATE_DECRYPT_EN
    assign w_dec = bus.dec_mode & bus.ct_en;
`else
    assign w_dec = 1'b0;
`endif

    assign w_tag_room = {1'b0, r_count} < TAG_LIMIT;

    acorn_step_func u_step (
        .i_state (r_state),
        .i_mbit  (bus.mbit_in),
        .i_ca    (bus.ca_in),
        .i_cb    (bus.cb_in),
        .i_dec   (w_dec),
        .o_ks    (w_ks),
        .o_next  (w_next)
    );

    // State, ciphertext and tag registers; clr outranks step_en.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all flops so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state     <= '0;
            r_tag       <= '0;
            r_count     <= '0;
            r_ct_bit    <= 1'b0;
            r_ct_valid  <= 1'b0;
            r_tag_valid <= 1'b0;
        end else if (bus.clr) begin
            r_state     <= '0;
            r_tag       <= '0;
            r_count     <= '0;
            r_ct_bit    <= 1'b0;
            r_ct_valid  <= 1'b0;
            r_tag_valid <= 1'b0;
        end else begin
            r_ct_valid <= 1'b0;
            if (bus.step_en) begin
                r_state <= w_next;
                // Tag phase wins over plaintext phase for the output strobe.
                if (bus.ct_en && !bus.tag_en) begin
                    r_ct_bit   <= bus.mbit_in ^ w_ks;
                    r_ct_valid <= 1'b1;
                end
                if (bus.tag_en && w_tag_room) begin
                    r_tag   <= {w_ks, r_tag[TAG_BITS-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == TAG_LAST) begin
                        r_tag_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ct_bit    = r_ct_bit;
    assign bus.ct_valid  = r_ct_valid;
    assign bus.tag_out   = r_tag;
    assign bus.tag_valid = r_tag_valid;

endmodule

// File: tb/tb_acorn_state_update.sv
// Directed self-checking bench for acorn_state_update with a bit-level
// reference model of the ACORN step. Decryption round-trip is exercised
// when ACORN_STATE_DECRYPT_EN is defined; otherwise dec_mode is shown inert.
module tb_acorn_state_update;

    localparam int NB = 293;
    localparam int TB = 128;

    logic clk = 1'b0;
    logic rst_n;

    acorn_state_update_if #(.TAG_BITS(TB)) bus ();

    acorn_state_update #(.TAG_BITS(TB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    bit [NB-1:0] m_state;
    bit [TB-1:0] m_tag;
    int          m_count;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit fmaj(input bit x, input bit y, input bit z);
        return (x && y) != ((x && z) != (y && z));
    endfunction

    task automatic model_reset();
        m_state = '0;
        m_tag   = '0;
        m_count = 0;
    endtask

    task automatic model_step(input bit mb, input bit ca, input bit cb, input bit dec,
                              input bit tagen, output bit ks);
        bit [NB-1:0] s;
        bit m, f, chv;
        s = m_state;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        chv = s[230] ? s[111] : s[66];
        ks  = s[12] ^ s[154] ^ fmaj(s[235], s[61], s[193]) ^ chv;
        m   = dec ? (mb ^ ks) : mb;
        f   = s[0] ^ !s[107] ^ fmaj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks) ^ m;
        for (int i = 0; i < NB - 1; i++) m_state[i] = s[i + 1];
        m_state[NB-1] = f;
        if (tagen && m_count < TB) begin
            m_tag = {ks, m_tag[TB-1:1]};
            m_count++;
        end
    endtask

    task automatic idle_inputs();
        bus.clr = 0; bus.step_en = 0; bus.mbit_in = 0; bus.ca_in = 0; bus.cb_in = 0;
        bus.ct_en = 0; bus.tag_en = 0; bus.dec_mode = 0;
    endtask

    // One DUT step plus the matching model step; returns the model keystream bit.
    task automatic do_step(input bit mb, input bit ca, input bit cb, input bit cten,
                           input bit tagen, input bit dec, output bit ks);
        bit dec_eff;
`ifdef ACORN_STATE_DECRYPT_EN
        dec_eff = dec & cten;
`else
        dec_eff = 1'b0;
`endif
        bus.step_en = 1; bus.mbit_in = mb; bus.ca_in = ca; bus.cb_in = cb;
        bus.ct_en = cten; bus.tag_en = tagen; bus.dec_mode = dec;
        model_step(mb, ca, cb, dec_eff, tagen, ks);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_clr(input bit with_step);
        bus.clr = 1; bus.step_en = with_step; bus.mbit_in = 1; bus.ca_in = 1;
        bus.cb_in = 1; bus.ct_en = 1; bus.tag_en = 1;
        @(posedge clk);
        #1;
        idle_inputs();
        model_reset();
    endtask

    bit          ks;
    bit [TB-1:0] tag_hold;
    bit [TB-1:0] pt_bits;
    bit [TB-1:0] ct_bits;
    bit [TB-1:0] tag_enc;

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        #12;
        check("reset_ct_bit",    NB'(bus.ct_bit),    '0);
        check("reset_ct_valid",  NB'(bus.ct_valid),  '0);
        check("reset_tag_out",   NB'(bus.tag_out),   '0);
        check("reset_tag_valid", NB'(bus.tag_valid), '0);
        check("reset_state",     dut.r_state,        '0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Zero state, all-zero inputs: f = 1 every step, ks stays 0.
        do_clr(1'b0);
        for (int i = 0; i < 10; i++) begin
            do_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ks);
            check($sformatf("zero_run_ks_%0d", i), NB'(bus.ct_bit), '0);
        end
        check("zero_run_ct_valid", NB'(bus.ct_valid), NB'(1));
        check("zero_run_state", dut.r_state, {10'h3FF, 283'b0});

        // Single plaintext step from zero state.
        do_clr(1'b0);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ks);
        check("ct1_ct_bit",   NB'(bus.ct_bit),   NB'(1));
        check("ct1_ct_valid", NB'(bus.ct_valid), NB'(1));
        check("ct1_s292",     NB'(dut.r_state[292]), '0);
        @(posedge clk);
        #1;
        check("ct1_valid_drop", NB'(bus.ct_valid), '0);
        check("ct1_bit_hold",   NB'(bus.ct_bit),   NB'(1));
        check("idle_state_hold", dut.r_state, NB'(m_state));

        // Tag collection with ct_en also high: strobe suppressed, ks captured.
        do_clr(1'b0);
        for (int i = 1; i <= 130; i++) begin
            do_step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ks);
            if (i == 127) check("tag_valid_before", NB'(bus.tag_valid), '0);
            if (i == 128) begin
                check("tag_valid_rise", NB'(bus.tag_valid), NB'(1));
                check("tag_value_128",  NB'(bus.tag_out),   NB'(m_tag));
                tag_hold = bus.tag_out;
            end
        end
        check("tag_and_ct_no_valid", NB'(bus.ct_valid),  '0);
        check("tag_frozen",          NB'(bus.tag_out),   NB'(tag_hold));
        check("tag_valid_held",      NB'(bus.tag_valid), NB'(1));
        check("tag_count_frozen",    NB'(dut.r_count),   NB'(128));
        check("tag_state_model",     dut.r_state,        NB'(m_state));

        // clr together with step_en: everything zero, no step applied.
        do_clr(1'b1);
        check("clr_state",     dut.r_state,        '0);
        check("clr_tag_out",   NB'(bus.tag_out),   '0);
        check("clr_tag_valid", NB'(bus.tag_valid), '0);
        check("clr_count",     NB'(dut.r_count),   '0);
        check("clr_ct_bit",    NB'(bus.ct_bit),    '0);
        check("clr_ct_valid",  NB'(bus.ct_valid),  '0);

        // Asynchronous reset in the middle of a tag.
        for (int i = 0; i < 60; i++) begin
            do_step(i[0], i[1], i[2], 1'b0, 1'b1, 1'b0, ks);
        end
        check("mid_tag_count", NB'(dut.r_count), NB'(60));
        check("mid_tag_model", NB'(bus.tag_out), NB'(m_tag));
        #2;
        rst_n = 0;
        #1;
        check("async_rst_tag_out",   NB'(bus.tag_out),   '0);
        check("async_rst_tag_valid", NB'(bus.tag_valid), '0);
        check("async_rst_state",     dut.r_state,        '0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < TB; i++) begin
            do_step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, ks);
        end
        check("fresh_tag_value", NB'(bus.tag_out),   NB'(m_tag));
        check("fresh_tag_valid", NB'(bus.tag_valid), NB'(1));

`ifdef ACORN_STATE_DECRYPT_EN
        // Encrypt then decrypt from the same zero start state.
        do_clr(1'b0);
        for (int i = 0; i < TB; i++) begin
            pt_bits[i] = 1'($urandom);
            do_step(pt_bits[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ks);
            ct_bits[i] = bus.ct_bit;
            if (i < 4) check($sformatf("enc_ct_%0d", i), NB'(bus.ct_bit), NB'(pt_bits[i] ^ ks));
        end
        for (int i = 0; i < TB; i++) do_step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ks);
        check("enc_tag_model", NB'(bus.tag_out), NB'(m_tag));
        tag_enc = bus.tag_out;
        do_clr(1'b0);
        for (int i = 0; i < TB; i++) begin
            do_step(ct_bits[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ks);
            if (bus.ct_bit !== pt_bits[i]) check($sformatf("dec_pt_%0d", i), NB'(bus.ct_bit), NB'(pt_bits[i]));
        end
        check("dec_state_match", dut.r_state, NB'(m_state));
        for (int i = 0; i < TB; i++) do_step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ks);
        check("dec_tag_equal", NB'(bus.tag_out), NB'(tag_enc));
`else
        // dec_mode must have no effect when decryption is not built in.
        do_clr(1'b0);
        for (int i = 0; i < 40; i++) begin
            pt_bits[i] = 1'($urandom);
            do_step(pt_bits[i], 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ks);
            ct_bits[i] = bus.ct_bit;
            tag_enc[i] = pt_bits[i] ^ ks;
        end
        check("nodec_ct_bits", NB'(ct_bits[39:0]), NB'(tag_enc[39:0]));
        check("nodec_state",   dut.r_state,        NB'(m_state));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
